// File: rtl/conv_out_collector.sv
// conv_out_collector: tracks the raster position of each written pixel, keeps
// convolution results whose 3x3 window lies fully inside the image, tags them
// with output coordinates and end-of-frame, and buffers them in a
// first-word-fall-through FIFO with registered outputs and almost_full
// back-pressure toward the pixel source.
module conv_out_collector #(
  parameter int unsigned IMG_W     = 502,
  parameter int unsigned IMG_H     = 502,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [7:0]                 conv_in,
  output logic [7:0]                 out_data,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       frame_done
);

  localparam int unsigned RW       = $clog2(IMG_H);
  localparam int unsigned CW       = $clog2(IMG_W);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned OW       = AW + 1;
  localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

  typedef struct packed {
    logic [7:0]    data;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
  } entry_t;

  // Raster position of the pixel being written
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          at_eol;
  logic          at_eof;

  // Capture stage: describes the result that conv_in will carry next cycle
  logic          cap;
  logic [RW-1:0] cap_row;
  logic [CW-1:0] cap_col;
  logic          cap_last;

  // FIFO storage and control
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] count;

  logic          full_c;
  logic          pop_c;
  logic          accept_c;
  logic          drop_c;
  entry_t        push_entry_c;
  logic [AW-1:0] rd_next_c;
  logic [OW-1:0] count_next_c;
  entry_t        head_next_c;

  // Frame boundary decode
  always_comb begin
    at_eol = (col == CW'(IMG_W - 1));
    at_eof = at_eol && (row == RW'(IMG_H - 1));
  end

  // Position counters advance on each written pixel, wrapping at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (we) begin
      if (at_eol) begin
        col <= '0;
        row <= at_eof ? '0 : RW'(row + RW'(1));
      end else begin
        col <= CW'(col + CW'(1));
      end
    end
  end

  // One-cycle pulse after the last pixel of a frame is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= we && at_eof;
    end
  end

  // Capture stage: remember whether the window of this pixel is fully inside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap      <= 1'b0;
      cap_row  <= '0;
      cap_col  <= '0;
      cap_last <= 1'b0;
    end else if (we) begin
      cap      <= (row >= RW'(2)) && (col >= CW'(2));
      cap_row  <= RW'(row - RW'(2));
      cap_col  <= CW'(col - CW'(2));
      cap_last <= at_eof;
    end else begin
      cap      <= 1'b0;
    end
  end

  // FIFO push/pop arbitration and next fall-through head
  always_comb begin
    push_entry_c.data = conv_in;
    push_entry_c.row  = cap_row;
    push_entry_c.col  = cap_col;
    push_entry_c.last = cap_last;

    full_c       = (count == OW'(DEPTH));
    pop_c        = out_valid && out_ready;
    accept_c     = cap && (!full_c || pop_c);
    drop_c       = cap && full_c && !pop_c;
    rd_next_c    = pop_c ? AW'(rd_ptr + AW'(1)) : rd_ptr;
    count_next_c = OW'(count + OW'(accept_c) - OW'(pop_c));

    // The pushed entry becomes the head when it lands in the next read slot
    if (accept_c && (wr_ptr == rd_next_c)) begin
      head_next_c = push_entry_c;
    end else begin
      head_next_c = mem[rd_next_c];
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr] <= push_entry_c;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept_c) begin
        wr_ptr <= AW'(wr_ptr + AW'(1));
      end
      rd_ptr <= rd_next_c;
      count  <= count_next_c;
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

  // Registered head-of-FIFO outputs; stable while the head is not taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= (count_next_c != '0);
      out_data  <= head_next_c.data;
      out_row   <= head_next_c.row;
      out_col   <= head_next_c.col;
      out_last  <= head_next_c.last;
    end
  end

  // Throttle request derived from registered occupancy
  always_comb begin
    almost_full = (count >= OW'(AF_LEVEL));
  end

endmodule

// File: tb/tb_conv_out_collector.sv
// Bench for conv_out_collector: small 5x4 image, 4-deep FIFO.
module tb_conv_out_collector;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned AF = 1;
  localparam int unsigned RW = $clog2(H);
  localparam int unsigned CW = $clog2(W);
  localparam int unsigned EW = 8 + RW + CW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [7:0]    conv_in = 8'd0;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;
  logic          out_valid;
  logic          almost_full;
  logic          overflow;
  logic          frame_done;

  conv_out_collector #(
    .IMG_W(W), .IMG_H(H), .DEPTH(D), .AF_MARGIN(AF)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .conv_in(conv_in),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .almost_full(almost_full), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  int fd_cnt = 0;

  // Reference model state
  logic [EW-1:0] exp_q[$];
  int            occ = 0;
  int            pix = 0;
  bit            pend_keep = 0;
  int            pend_r = 0;
  int            pend_c = 0;
  bit            pend_last = 0;
  bit            exp_ovf = 0;
  bit            exp_fd = 0;
  bit            cur_we = 0;
  bit            cur_ready = 0;
  logic [7:0]    cur_conv = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply the rules of one clock edge to the model, using the inputs seen there
  task automatic model_edge();
    bit pop_m;
    int r;
    int c;
    pop_m = (occ > 0) && cur_ready;
    if (pend_keep) begin
      if (occ - int'(pop_m) < int'(D)) begin
        exp_q.push_back({cur_conv, RW'(pend_r), CW'(pend_c), pend_last});
        occ++;
      end else begin
        exp_ovf = 1;
      end
    end
    occ -= int'(pop_m);
    exp_fd = cur_we && (pix == int'(W * H) - 1);
    if (cur_we) begin
      r = pix / int'(W);
      c = pix % int'(W);
      pend_keep = (r >= 2) && (c >= 2);
      pend_r    = r - 2;
      pend_c    = c - 2;
      pend_last = exp_fd;
      pix       = (pix + 1) % int'(W * H);
    end else begin
      pend_keep = 0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then check status outputs
  task automatic cycle(input bit w, input bit r);
    cur_we    = w;
    cur_ready = r;
    cur_conv  = 8'($urandom);
    we        = w;
    out_ready = r;
    conv_in   = cur_conv;
    @(posedge clk);
    #1;
    model_edge();
    if (frame_done) fd_cnt++;
    chk("out_valid", 32'(out_valid), 32'(occ > 0));
    chk("almost_full", 32'(almost_full), 32'(occ >= int'(D - AF)));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (occ > 0 && n < 40) begin
      cycle(1'b0, 1'b1);
      n++;
    end
    chk("drain_timeout", 32'(occ), 32'd0);
  endtask

  task automatic frame(input bit toggle, input bit ready);
    for (int i = 0; i < int'(W * H); i++) begin
      cycle(1'b1, ready);
      if (toggle) cycle(1'b0, ready);
    end
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once
  task automatic do_reset();
    #1;
    rst = 1'b1;
    we = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_row", 32'(out_row), 32'd0);
    chk("rst_out_col", 32'(out_col), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    occ = 0; pix = 0; pend_keep = 0; exp_ovf = 0; exp_fd = 0;
    cur_we = 0; cur_ready = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: head must match the oldest expected entry; consume on handshake
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0h expected none at %0t",
                 {out_data, out_row, out_col, out_last}, $time);
      end else begin
        chk("head_entry", 32'({out_data, out_row, out_col, out_last}), 32'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    int n0;
    int f0;
    int n;
    #3;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous write, consumer always ready
    n0 = n_out; f0 = fd_cnt;
    frame(1'b0, 1'b1);
    drain();
    chk("frame_outputs", 32'(n_out - n0), 32'd6);
    chk("frame_done_count", 32'(fd_cnt - f0), 32'd1);

    // Write strobe toggling every cycle
    n0 = n_out;
    frame(1'b1, 1'b1);
    drain();
    chk("toggle_outputs", 32'(n_out - n0), 32'd6);

    // Two back-to-back frames
    n0 = n_out; f0 = fd_cnt;
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b1);
    drain();
    chk("two_frame_outputs", 32'(n_out - n0), 32'd12);
    chk("two_frame_done_count", 32'(fd_cnt - f0), 32'd2);

    // Consumer stalled for a whole frame: 4 held, 2 dropped
    n0 = n_out;
    frame(1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    chk("stall_almost_full", 32'(almost_full), 32'd1);
    chk("stall_overflow", 32'(overflow), 32'd1);
    chk("stall_no_output", 32'(n_out - n0), 32'd0);
    drain();
    chk("stall_drain_outputs", 32'(n_out - n0), 32'd4);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO with pop on the push cycle must not drop
    do_reset();
    n0 = n_out;
    for (int i = 0; i < int'(W * H); i++) cycle(1'b1, occ == int'(D));
    drain();
    chk("full_pop_push_overflow", 32'(overflow), 32'd0);
    chk("full_pop_push_outputs", 32'(n_out - n0), 32'd6);

    // Reset in the middle of a frame, then a clean frame
    for (int i = 0; i <= 12; i++) cycle(1'b1, 1'b1);
    do_reset();
    n0 = n_out;
    frame(1'b0, 1'b1);
    drain();
    chk("post_reset_outputs", 32'(n_out - n0), 32'd6);

    // Random write strobe and consumer readiness over several frames
    n = 0;
    while (n < 200) begin
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0);
      n++;
    end
    drain();
    chk("random_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
